// File: rtl/stream_pad_engine.sv
// stream_pad_engine: wraps an n x n row-major feature stream in a p-wide border
// of a programmable pad value, emitting (n+2p)^2 beats with row/frame markers.
module stream_pad_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned MAX_N      = 32,
  parameter int unsigned MAX_P      = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [$clog2(MAX_N+1)-1:0]       cfg_n,
  input  logic [$clog2(MAX_P+1)-1:0]       cfg_p,
  input  logic [DATA_WIDTH-1:0]            pad_value,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]   out_data,
  output logic                             out_row_last,
  output logic                             out_frame_last
);

  localparam int unsigned CW = $clog2(MAX_N + 2*MAX_P + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, p_q, row_q, col_q;
  logic [CW-1:0]   side_w, int_end;
  logic [DATA_WIDTH-1:0] pad_q;
  logic            last_loaded_q;
  logic            cfg_ok, is_pad, can_load, load, col_end, row_end, final_acc;
  logic            done_d, cfg_err_d, accept_cfg;

  // Position classification and load/handshake qualification
  always_comb begin
    side_w    = n_q + (p_q << 1);
    int_end   = n_q + p_q;
    is_pad    = (row_q < p_q) || (row_q >= int_end) || (col_q < p_q) || (col_q >= int_end);
    col_end   = (col_q == side_w - CW'(1));
    row_end   = (row_q == side_w - CW'(1));
    can_load  = (state_q == RUN) && !last_loaded_q && (!out_valid || out_ready);
    in_ready  = can_load && !is_pad;
    load      = can_load && (is_pad || in_valid);
    final_acc = out_valid && out_ready && out_frame_last;
    cfg_ok    = (cfg_n != '0) && (32'(cfg_n) <= MAX_N) && (32'(cfg_p) <= MAX_P);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status pulse decode
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    accept_cfg = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept_cfg = 1'b1;
            state_d    = RUN;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (final_acc) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // Config latch, position counters and the single output register
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q            <= '0;
      p_q            <= '0;
      pad_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      last_loaded_q  <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_row_last   <= 1'b0;
      out_frame_last <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      done    <= done_d;
      cfg_err <= cfg_err_d;
      if (accept_cfg) begin
        n_q           <= CW'(cfg_n);
        p_q           <= CW'(cfg_p);
        pad_q         <= pad_value;
        row_q         <= '0;
        col_q         <= '0;
        last_loaded_q <= 1'b0;
      end
      if (load) begin
        out_valid      <= 1'b1;
        out_data       <= is_pad ? {CHANNELS{pad_q}} : in_data;
        out_row_last   <= col_end;
        out_frame_last <= col_end && row_end;
        if (col_end) begin
          col_q <= '0;
          // Hold row at the final position so nothing else loads this frame
          if (row_end) last_loaded_q <= 1'b1;
          else         row_q         <= row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid      <= 1'b0;
        out_row_last   <= 1'b0;
        out_frame_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_pad_engine.sv
// Bench for stream_pad_engine: table of frame configurations plus directed
// sequences for config errors and mid-frame reset.
module tb_stream_pad_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned MN = 32;
  localparam int unsigned MP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [5:0]    cfg_n;
  logic [1:0]    cfg_p;
  logic [DW-1:0] pad_value;
  logic          busy, done, cfg_err;
  logic          in_valid, in_ready;
  logic [CH*DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [CH*DW-1:0] out_data;
  logic          out_row_last, out_frame_last;

  int tests  = 0;
  int failed = 0;

  stream_pad_engine #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_N(MN), .MAX_P(MP)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_n(cfg_n), .cfg_p(cfg_p),
    .pad_value(pad_value), .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_frame_last(out_frame_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        n;
    int        p;
    logic [7:0] pad;
    bit        bp;
    bit        hold;
    int        exp_cyc;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CH*DW-1:0] beat(input int k);
    return {8'(k + 129), 8'(k + 65), 8'(k + 1)};
  endfunction

  task automatic check_idle_outputs(input string name);
    check(name, 64'({out_valid, out_data, out_row_last, out_frame_last, busy, done, cfg_err, in_ready}), 64'd0);
  endtask

  // Runs one frame; out_ready/in_valid random when bp; start held high with a
  // bad config during the frame when hold, to show start is ignored outside IDLE.
  task automatic run_frame(input int n, input int p, input logic [7:0] pad,
                           input bit bp, input bit hold, input int exp_cyc);
    int w = n + 2*p;
    int total = w * w;
    int prod = 0, cons = 0, j = 0, err_seen = 0;
    bit fin = 1'b0, stall = 1'b0;
    logic [CH*DW+1:0] saved = '0;
    logic [CH*DW-1:0] exp_d;
    int r, c;
    @(negedge clk);
    start = 1'b1; cfg_n = 6'(n); cfg_p = 2'(p); pad_value = pad;
    in_valid = 1'b0; out_ready = 1'b0;
    while (!fin && j < 5000) begin
      @(negedge clk);
      j++;
      if (hold) begin start = 1'b1; cfg_n = 6'd0; end
      else start = 1'b0;
      pad_value = ~pad;
      if (cfg_err) err_seen++;
      if (j == 1) check("busy_in_run", 64'(busy), 64'd1);
      if (done) begin
        start = 1'b0;
        fin = 1'b1;
        if (exp_cyc != 0) check("done_latency", 64'(j), 64'(exp_cyc));
        check("done_busy_low", 64'(busy), 64'd0);
        check("beats_out", 64'(cons), 64'(total));
        check("beats_in", 64'(prod), 64'(n * n));
      end else begin
        out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_valid  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data   = beat(prod);
        #1;
        if (stall)
          check("stall_hold", 64'({out_valid, out_data, out_row_last, out_frame_last}),
                64'({1'b1, saved}));
        if (in_valid && in_ready) prod++;
        if (out_valid && out_ready) begin
          r = cons / w;
          c = cons % w;
          if (r < p || r >= n + p || c < p || c >= n + p) exp_d = {CH{pad}};
          else exp_d = beat((r - p) * n + (c - p));
          check($sformatf("beat%0d_n%0d_p%0d", cons, n, p),
                64'({out_data, out_row_last, out_frame_last}),
                64'({exp_d, c == w - 1, cons == total - 1}));
          cons++;
        end
        stall = out_valid && !out_ready;
        saved = {out_data, out_row_last, out_frame_last};
      end
    end
    if (!fin) begin
      failed++;
      $display("FAIL frame_timeout: got no done expected done within 5000 cycles");
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    check("no_cfg_err_in_run", 64'(err_seen), 64'd0);
    @(negedge clk);
    check("idle_after_done", 64'({busy, done, cfg_err, out_valid}), 64'd0);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{n: 4,  p: 1, pad: 8'h00, bp: 1'b0, hold: 1'b0, exp_cyc: 38};
    tbl[1] = '{n: 4,  p: 1, pad: 8'h00, bp: 1'b1, hold: 1'b1, exp_cyc: 0};
    tbl[2] = '{n: 2,  p: 2, pad: 8'h80, bp: 1'b0, hold: 1'b0, exp_cyc: 38};
    tbl[3] = '{n: 32, p: 0, pad: 8'h5A, bp: 1'b0, hold: 1'b0, exp_cyc: 1026};
    tbl[4] = '{n: 1,  p: 2, pad: 8'hFF, bp: 1'b1, hold: 1'b0, exp_cyc: 0};
    tbl[5] = '{n: 3,  p: 0, pad: 8'h11, bp: 1'b1, hold: 1'b1, exp_cyc: 0};
    tbl[6] = '{n: 32, p: 2, pad: 8'h3C, bp: 1'b0, hold: 1'b0, exp_cyc: 1298};

    reset = 1'b1; start = 1'b0; cfg_n = '0; cfg_p = '0; pad_value = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].n, tbl[i].p, tbl[i].pad, tbl[i].bp, tbl[i].hold, tbl[i].exp_cyc);

    // Rejected configurations: n=0, n=MAX_N+1, p=MAX_P+1
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1;
      cfg_n = (k == 0) ? 6'd0 : (k == 1) ? 6'(MN + 1) : 6'd5;
      cfg_p = (k == 2) ? 2'(MP + 1) : 2'd1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("cfg_err_pulse%0d", k), 64'({cfg_err, busy, out_valid}), 64'b100);
      @(negedge clk);
      check($sformatf("cfg_err_clear%0d", k), 64'({cfg_err, busy, out_valid}), 64'b000);
    end

    // Reset after 10 accepted output beats drops the frame without done
    @(negedge clk);
    start = 1'b1; cfg_n = 6'd4; cfg_p = 2'd1; pad_value = 8'h00;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = beat(0);
    cnt = 0;
    for (int t = 0; t < 40 && cnt < 10; t++) begin
      #1;
      if (out_valid && out_ready) cnt++;
      @(negedge clk);
    end
    check("beats_before_reset", 64'(cnt), 64'd10);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_frame_reset");
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset_idle");
    run_frame(4, 1, 8'h00, 1'b0, 1'b0, 38);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
